// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - seven-segment scan capture into decoded digit frames
//
// Samples a multiplexed, active-low seven-segment display bus, waits for each
// digit strobe to settle for STABLE_CNT identical samples, decodes the
// pattern and assembles one frame of NDIG digits for a valid/ready consumer.
//
// Build option: SEG_CAPTURE_OVERRUN_EN enables the sticky overrun flag;
// when undefined, overrun is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   seg_in[6:0]  active-low segments, [6]=a .. [0]=g
//   an_in        active-low digit strobes, bit i low selects slot i
//   digits       presented frame, slot i at [4i+3:4i]
//   err          per-slot unrecognised-pattern flags for the presented frame
//   frame_valid  presented frame available
//   frame_ready  consumer accepts the presented frame
//   overrun      sticky: a captured digit overwrote an unconsumed one
module seg_capture #(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic [NDIG-1:0]     an_in,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     err,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                overrun
);

  // Counter runs one past the capture value and parks there, so a long
  // dwell captures exactly once.
  localparam int CW = $clog2(STABLE_CNT + 2);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CNT + 1);

  typedef enum logic {COLLECT, PRESENT} state_t;
  state_t state;

  logic [6:0]      seg_q;
  logic [NDIG-1:0] an_q;
  logic [6:0]      hold_seg;
  logic [NDIG-1:0] hold_an;
  logic [CW-1:0]   cnt;

  logic            qual;
  logic            same;
  logic            cap;
  logic [NDIG-1:0] cap_bit;
  logic [IW-1:0]   cap_idx;
  logic [3:0]      dec_code;
  logic            dec_err;

  logic [NDIG-1:0] mask;
  logic [3:0]      work_dig [NDIG];
  logic [NDIG-1:0] work_err;
  logic            mask_full;
  logic            mask_clr;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = {1'b0, 4'h0};
      7'b1001111: decode = {1'b0, 4'h1};
      7'b0010010: decode = {1'b0, 4'h2};
      7'b0000110: decode = {1'b0, 4'h3};
      7'b1001100: decode = {1'b0, 4'h4};
      7'b0100100: decode = {1'b0, 4'h5};
      7'b0100000: decode = {1'b0, 4'h6};
      7'b0001111: decode = {1'b0, 4'h7};
      7'b0000000: decode = {1'b0, 4'h8};
      7'b0000100: decode = {1'b0, 4'h9};
      7'b1111111: decode = {1'b0, 4'hF};
      default:    decode = {1'b1, 4'hE};
    endcase
  endfunction

  assign qual = $onehot(~an_q);
  assign same = (seg_q == hold_seg) && (an_q == hold_an);

  // The capture acts on the held pattern one cycle after the counter
  // reaches STABLE_CNT, which may already be the next strobe's first cycle.
  assign cap     = (cnt == CNT_HIT);
  assign cap_bit = ~hold_an;

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!hold_an[i]) cap_idx = IW'(i);
    end
  end

  always_comb begin
    {dec_err, dec_code} = decode(hold_seg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= '1;
      an_q     <= '1;
      hold_seg <= '1;
      hold_an  <= '1;
      cnt      <= '0;
    end else begin
      seg_q <= seg_in;
      an_q  <= an_in;
      if (!qual) begin
        cnt <= '0;
      end else begin
        // hold only tracks qualified samples so a pending capture still
        // sees its pattern if the next sample is unqualified
        hold_seg <= seg_q;
        hold_an  <= an_q;
        if (same) begin
          if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
        end else begin
          cnt <= CW'(1);
        end
      end
    end
  end

  assign mask_full = &mask;
  // In PRESENT frame_valid is always high, so frame_ready alone is the handshake.
  assign mask_clr  = mask_full && ((state == COLLECT) || frame_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      mask        <= '0;
      digits      <= '1;
      err         <= '0;
      frame_valid <= 1'b0;
      work_err    <= '0;
      for (int i = 0; i < NDIG; i++) work_dig[i] <= 4'hF;
    end else begin
      if (cap) begin
        work_dig[cap_idx] <= dec_code;
        work_err[cap_idx] <= dec_err;
      end
      // a capture on the clearing edge belongs to the next frame
      mask <= (mask_clr ? '0 : mask) | (cap ? cap_bit : '0);

      case (state)
        COLLECT: begin
          if (mask_full) begin
            for (int i = 0; i < NDIG; i++) digits[4*i +: 4] <= work_dig[i];
            err         <= work_err;
            frame_valid <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (frame_ready) begin
            if (mask_full) begin
              for (int i = 0; i < NDIG; i++) digits[4*i +: 4] <= work_dig[i];
              err <= work_err;
            end else begin
              frame_valid <= 1'b0;
              state       <= COLLECT;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef SEG_CAPTURE_OVERRUN_EN
  // Overwriting a filled slot loses data unless the slot is being handed
  // off to the presented frame on this same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (cap && !mask_clr && |(mask & cap_bit)) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule
